// File: rtl/test_st_source.sv
// Streaming traffic generator: on start, emits num_bursts bursts of burst_len beats
// separated by gap_cycles idle cycles, with incrementing, LFSR or walking-one payload.
module test_st_source #(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_W      = 16,
  parameter int GAP_W      = 8,
  parameter int NUM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [NUM_W-1:0]      num_bursts,
  input  logic [GAP_W-1:0]      gap_cycles,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      beat_count,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on any rising clk edge where valid && ready.
  // While valid is high and ready is low, st_data and valid hold stable.
  // ready is ignored while valid is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int          LANES     = DATA_WIDTH / 32;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Mode 3 is reserved and falls through to the incrementing pattern.
  function automatic logic [DATA_WIDTH-1:0] make_word(input logic [1:0]  m,
                                                      input logic [31:0] n,
                                                      input logic [31:0] l);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    case (m)
      2'd1: for (int i = 0; i < LANES; i++) w[i*32 +: 32] = l ^ 32'(i);
      2'd2: w = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (n % 32'(DATA_WIDTH));
      default: for (int i = 0; i < LANES; i++) w[i*32 +: 32] = n * 32'(LANES) + 32'(i);
    endcase
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]           seq_q, seq_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [NUM_W-1:0]      bursts_left_q, bursts_left_d;

  logic [31:0] seq_inc;
  logic [31:0] lfsr_adv;
  logic        last_beat;

  assign seq_inc   = seq_q + 32'd1;
  assign lfsr_adv  = lfsr_step(lfsr_q);
  assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    valid_d       = valid_q;
    done_d        = 1'b0;
    beat_cnt_d    = beat_cnt_q;
    seq_d         = seq_q;
    lfsr_d        = lfsr_q;
    mode_d        = mode_q;
    len_d         = len_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    bursts_left_d = bursts_left_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0 && num_bursts != '0) begin
            mode_d        = mode;
            len_d         = burst_len;
            gap_d         = gap_cycles;
            bursts_left_d = num_bursts;
            seq_d         = 32'd0;
            lfsr_d        = LFSR_SEED;
            beat_cnt_d    = '0;
            data_d        = make_word(mode, 32'd0, LFSR_SEED);
            valid_d       = 1'b1;
            state_d       = S_RUN;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        if (valid_q && ready) begin
          // Next word is loaded on the accepting edge, even across a gap.
          seq_d  = seq_inc;
          lfsr_d = lfsr_adv;
          data_d = make_word(mode_q, seq_inc, lfsr_adv);
          if (last_beat) begin
            beat_cnt_d    = '0;
            bursts_left_d = bursts_left_q - NUM_W'(1);
            if (bursts_left_q == NUM_W'(1)) begin
              valid_d = 1'b0;
              state_d = S_FIN;
            end else if (gap_q != '0) begin
              valid_d   = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          valid_d = 1'b1;
          state_d = S_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      beat_cnt_q    <= '0;
      seq_q         <= 32'd0;
      lfsr_q        <= LFSR_SEED;
      mode_q        <= 2'd0;
      len_q         <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      bursts_left_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      beat_cnt_q    <= beat_cnt_d;
      seq_q         <= seq_d;
      lfsr_q        <= lfsr_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      bursts_left_q <= bursts_left_d;
    end
  end

  assign st_data    = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign beat_count = beat_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_test_st_source.sv
// Directed bench for test_st_source: burst shape, gaps, payload modes, backpressure,
// zero-length start and mid-run reset.
module tb_test_st_source;

  localparam int DW    = 256;
  localparam int LEN_W = 16;
  localparam int GAP_W = 8;
  localparam int NUM_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic             clk, rst, start, ready, valid, busy, done;
  logic [1:0]       mode, dbg_state;
  logic [LEN_W-1:0] burst_len, beat_count;
  logic [NUM_W-1:0] num_bursts;
  logic [GAP_W-1:0] gap_cycles;
  logic [DW-1:0]    st_data;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [DW-1:0]    got_q[$];
  logic [DW-1:0]    exp_q[$];
  logic [LEN_W-1:0] bc_q[$];
  logic             vpat_q[$];
  int done_cnt, done_cycle, stall_bad;
  bit timed_out, first_busy;

  test_st_source #(.DATA_WIDTH(DW), .LEN_W(LEN_W), .GAP_W(GAP_W), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
    .num_bursts(num_bursts), .gap_cycles(gap_cycles), .st_data(st_data),
    .valid(valid), .ready(ready), .busy(busy), .done(done),
    .beat_count(beat_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic pulse_start(input logic [1:0] m, input int len, input int num, input int gap);
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    burst_len = len[LEN_W-1:0]; num_bursts = num[NUM_W-1:0]; gap_cycles = gap[GAP_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Samples 1 time unit after each edge; records accepted beats, valid pattern and done.
  task automatic run_collect(input int max_cyc, input int rdy_pct, input int poke_at);
    logic [DW-1:0] prev_data;
    bit prev_stall;
    got_q.delete(); bc_q.delete(); vpat_q.delete();
    done_cnt = 0; done_cycle = -1; stall_bad = 0; timed_out = 1;
    first_busy = busy; prev_stall = 0; prev_data = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (prev_stall && (valid !== 1'b1 || st_data !== prev_data)) stall_bad++;
      vpat_q.push_back(valid);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 3) begin
        timed_out = 0;
        break;
      end
      ready = ($urandom_range(99) < rdy_pct);
      if (valid === 1'b1 && ready) begin
        got_q.push_back(st_data);
        bc_q.push_back(beat_count);
      end
      prev_stall = (valid === 1'b1) && !ready;
      prev_data  = st_data;
      start = (cyc == poke_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  function automatic int count_ones();
    int n = 0;
    foreach (vpat_q[i]) if (vpat_q[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_lfsr_next(input logic [31:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ 32'h8020_0003;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 0; ready = 0; mode = 0; burst_len = 0; num_bursts = 0; gap_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (st_data !== '0) begin fail_cnt++; $display("FAIL reset_data: got %0h expected 0", st_data); end
    tests_run++; if (valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests_run++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (beat_count !== '0) begin fail_cnt++; $display("FAIL reset_beat_count: got %0d expected 0", beat_count); end
    tests_run++; if (dbg_state !== ST_IDLE) begin fail_cnt++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    pulse_start(2'd0, 4, 1, 0);
    run_collect(50, 100, -1);
    tests_run++; if (timed_out) begin fail_cnt++; $display("FAIL single_timeout: got no done expected done"); end
    tests_run++; if (first_busy !== 1'b1) begin fail_cnt++; $display("FAIL single_busy: got %b expected 1", first_busy); end
    tests_run++; if (got_q.size() != 4) begin fail_cnt++; $display("FAIL single_beats: got %0d expected 4", got_q.size()); end
    tests_run++; if (vpat_q[0] !== 1'b1 || count_ones() != 4) begin fail_cnt++; $display("FAIL single_valid_shape: got first=%b ones=%0d expected first=1 ones=4", vpat_q[0], count_ones()); end
    foreach (got_q[k]) begin
      tests_run++;
      if (got_q[k][31:0] !== 32'(k * 8)) begin fail_cnt++; $display("FAIL single_lane0[%0d]: got %0d expected %0d", k, got_q[k][31:0], k * 8); end
    end
    tests_run++; if (got_q.size() > 3 && got_q[3][63:32] !== 32'd25) begin fail_cnt++; $display("FAIL single_lane1_w3: got %0d expected 25", got_q[3][63:32]); end
    tests_run++; if (done_cycle != 5 || done_cnt != 1) begin fail_cnt++; $display("FAIL single_done: got cycle=%0d count=%0d expected cycle=5 count=1", done_cycle, done_cnt); end
  endtask

  task automatic test_gap();
    int first1, last1, zeros;
    pulse_start(2'd0, 3, 2, 2);
    run_collect(50, 100, -1);
    first1 = -1; last1 = -1; zeros = 0;
    foreach (vpat_q[i]) if (vpat_q[i] === 1'b1) begin
      if (first1 < 0) first1 = i;
      last1 = i;
    end
    for (int i = first1; i <= last1 && first1 >= 0; i++) if (vpat_q[i] !== 1'b1) zeros++;
    tests_run++; if (timed_out) begin fail_cnt++; $display("FAIL gap_timeout: got no done expected done"); end
    tests_run++; if (got_q.size() != 6) begin fail_cnt++; $display("FAIL gap_beats: got %0d expected 6", got_q.size()); end
    tests_run++; if (zeros != 2) begin fail_cnt++; $display("FAIL gap_idle_cycles: got %0d expected 2", zeros); end
    tests_run++; if (got_q.size() > 3 && got_q[3][31:0] !== 32'd24) begin fail_cnt++; $display("FAIL gap_lane0_beat4: got %0d expected 24", got_q[3][31:0]); end
    foreach (bc_q[k]) begin
      tests_run++;
      if (bc_q[k] !== LEN_W'(k % 3)) begin fail_cnt++; $display("FAIL gap_beat_count[%0d]: got %0d expected %0d", k, bc_q[k], k % 3); end
    end
    tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL gap_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_mode3_back_to_back();
    pulse_start(2'd3, 2, 2, 0);
    run_collect(50, 100, -1);
    tests_run++; if (got_q.size() != 4 || count_ones() != 4) begin fail_cnt++; $display("FAIL b2b_beats: got beats=%0d ones=%0d expected 4 and 4", got_q.size(), count_ones()); end
    tests_run++; if (got_q.size() > 2 && got_q[2][95:64] !== 32'd18) begin fail_cnt++; $display("FAIL b2b_mode3_lane2_w2: got %0d expected 18", got_q[2][95:64]); end
    tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_lfsr_backpressure();
    logic [31:0]   l;
    logic [DW-1:0] w;
    exp_q.delete();
    l = 32'hACE1_0001;
    for (int k = 0; k < 64; k++) begin
      for (int ln = 0; ln < DW / 32; ln++) w[ln*32 +: 32] = l ^ 32'(ln);
      exp_q.push_back(w);
      l = ref_lfsr_next(l);
    end
    pulse_start(2'd1, 16, 4, 3);
    run_collect(1000, 50, -1);
    tests_run++; if (timed_out) begin fail_cnt++; $display("FAIL lfsr_timeout: got no done expected done"); end
    tests_run++; if (got_q.size() != 64) begin fail_cnt++; $display("FAIL lfsr_beats: got %0d expected 64", got_q.size()); end
    tests_run++; if (stall_bad != 0) begin fail_cnt++; $display("FAIL lfsr_stall_stable: got %0d violations expected 0", stall_bad); end
    foreach (got_q[k]) begin
      if (k < 64) begin
        tests_run++;
        if (got_q[k] !== exp_q[k]) begin fail_cnt++; $display("FAIL lfsr_word[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
    end
    tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL lfsr_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_walking_one();
    logic [DW-1:0] w;
    pulse_start(2'd2, 300, 1, 0);
    burst_len = 16'd5; mode = 2'd0; num_bursts = 8'd3;
    run_collect(400, 100, 50);
    tests_run++; if (timed_out) begin fail_cnt++; $display("FAIL walk_timeout: got no done expected done"); end
    tests_run++; if (got_q.size() != 300) begin fail_cnt++; $display("FAIL walk_beats: got %0d expected 300", got_q.size()); end
    foreach (got_q[k]) begin
      w = '0;
      w[k % DW] = 1'b1;
      tests_run++;
      if (got_q[k] !== w) begin fail_cnt++; $display("FAIL walk_word[%0d]: got %h expected %h", k, got_q[k], w); end
    end
    tests_run++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL walk_done_count: got %0d expected 1", done_cnt); end
    tests_run++; if (valid !== 1'b0 || busy !== 1'b0) begin fail_cnt++; $display("FAIL walk_idle_after: got valid=%b busy=%b expected 0 0", valid, busy); end
  endtask

  task automatic test_zero_len_and_reset();
    pulse_start(2'd0, 0, 3, 0);
    run_collect(20, 100, -1);
    tests_run++; if (count_ones() != 0 || got_q.size() != 0) begin fail_cnt++; $display("FAIL zlen_no_valid: got ones=%0d expected 0", count_ones()); end
    tests_run++; if (done_cycle != 1 || done_cnt != 1) begin fail_cnt++; $display("FAIL zlen_done: got cycle=%0d count=%0d expected cycle=1 count=1", done_cycle, done_cnt); end

    pulse_start(2'd0, 10, 1, 0);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (valid !== 1'b1 || dbg_state !== ST_RUN) begin fail_cnt++; $display("FAIL rst_pre_run: got valid=%b state=%0d expected 1 %0d", valid, dbg_state, ST_RUN); end
    rst = 1'b1;
    #1;
    tests_run++; if (valid !== 1'b0 || busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_async_ctrl: got valid=%b busy=%b expected 0 0", valid, busy); end
    tests_run++; if (st_data !== '0 || beat_count !== '0) begin fail_cnt++; $display("FAIL rst_async_data: got data=%0h bc=%0d expected 0 0", st_data, beat_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_collect(15, 100, -1);
    tests_run++; if (done_cnt != 0 || count_ones() != 0) begin fail_cnt++; $display("FAIL rst_no_done: got done=%0d valid_cycles=%0d expected 0 0", done_cnt, count_ones()); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_gap();
    test_mode3_back_to_back();
    test_lfsr_backpressure();
    test_walking_one();
    test_zero_len_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
